sha256_padder: RTL and testbench
================================

# sha256_padder

Upstream message-preparation stage for the SHA256 compression core. Accepts an arbitrary-length message as a byte stream and emits 512-bit SHA-256 blocks with FIPS 180-4 padding and the big-endian 64-bit bit-length already inserted. Each block is presented on a valid/ready handshake together with first/last flags, so the core can start from the initial hash constants or chain from the previous output.

## Interface
- LEN_W, 64: width of the internal message bit-length counter (≤64); the value is zero-extended to 64 bits in the length field.
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- in_data  input  8  message byte; the first byte lands in blk_data[511:504]
- in_valid  input  1  in_data is valid
- in_last  input  1  this byte is the final byte of the message (messages are ≥1 byte)
- in_ready  output  1  padder accepts a byte this cycle
- blk_data  output  512  padded block, big-endian, byte 0 = [511:504]
- blk_valid  output  1  blk_data holds a block
- blk_ready  input  1  consumer takes the block
- blk_first  output  1  block is the first of its message (core loads the IV)
- blk_last  output  1  block is the final block; the digest is valid after compression
- msg_bits  output  64  total message length in bits, valid with blk_last

## Operation
- Byte transfer: in_valid & in_ready at a rising edge. Block transfer: blk_valid & blk_ready.
- States: FILL, HOLD, PAD2, HOLD2.
- FILL: in_ready=1. Each accepted byte is written at position cnt (0..63); cnt increments and the byte counter increments. Let n be the number of bytes in the block after the current byte.
  - n=64 and not in_last: register a data block (last=0) and go to HOLD.
  - in_last with n≤55: register data, 0x80, zero fill, length in bytes 56..63, last=1. Go to HOLD.
  - in_last with 56≤n≤63: register data, 0x80, zero fill, last=0. Go to HOLD with pad2 flag = "zeros+len".
  - in_last with n=64: register data, last=0. Go to HOLD with pad2 flag = "0x80+zeros+len".
- HOLD: in_ready=0. blk_valid=1. On handshake:
  - If pad2 is pending: register the second block (blk_first=0, blk_last=1) and go to PAD2/HOLD2.
  - Else, if the block was last: clear the message counter and go to FILL with blk_first re-armed.
  - Else: go to FILL with cnt=0.
- HOLD2: same as HOLD for the second block; on handshake, return to FILL and clear the counters.
- blk_first=1 only on the first block emitted after reset or after a blk_last handshake.
- Length = bytes×8 modulo 2^LEN_W, big-endian in bits [63:0] of the final block. msg_bits reports the same value.
- blk_data, blk_first, blk_last and msg_bits are stable while blk_valid=1 and blk_ready=0.
- Reset, asynchronous at any time: state=FILL, cnt=0, length=0, blk_valid=0, blk_data=0, blk_first=0, blk_last=0, msg_bits=0, in_ready=1. Any partial message is discarded.

## Timing
- in_ready is combinational from state: 1 in FILL only. It is independent of in_valid and of blk_ready.
- Throughput is 1 byte/cycle in FILL.
- A block is registered on the edge that accepts its completing byte. blk_valid is high from the following cycle.
- The second padding block is registered on the same edge as the first block's handshake, so blk_valid stays high with no bubble.
- in_ready returns to 1 the cycle after the final block handshake.
- The minimum gap between two messages is 1 cycle (for a single-block message with blk_ready held at 1).
- Holding blk_ready high while blk_valid=0 has no effect.

## Test plan
- "hello world" (11 bytes, in_last on 0x64), blk_ready=1 -> one block 68656c6c6f20776f726c6480 followed by zeros, with [63:0]=0x58; first=1, last=1, msg_bits=88.
- 55×0x61 -> a single block; byte 55=0x80; [63:0]=0x1B8; first=last=1.
- 56×0x61 -> block 1 is data, byte 56=0x80, then zeros, first=1, last=0. Block 2 is all zero except [63:0]=0x1C0, first=0, last=1. blk_valid shows no bubble between blocks.
- 64×0x61 -> block 1 is pure data with last=0. Block 2 has [511:504]=0x80 and [63:0]=0x200, last=1.
- Backpressure: send "abc", hold blk_ready=0 for 10 cycles -> blk_valid=1, blk_data constant and in_ready=0 throughout, with no bytes accepted. The handshake completes on the cycle blk_ready rises.
- Reset mid-message: after 30 bytes, pulse reset_n low -> outputs return to their reset values. Then send "abc" -> block 61626380 followed by zeros, [63:0]=0x18, first=1, last=1.

Source files
------------

// File: rtl/sha256_padder_if.sv
// rtl/sha256_padder_if.sv - byte-in / block-out handshake bundle for sha256_padder
//
// Ports (signals):
//   in_data[7:0], in_valid, in_last : message byte stream into the padder
//   in_ready                        : padder accepts a byte this cycle
//   blk_data[511:0], blk_valid      : padded 512-bit block, big-endian
//   blk_ready                       : consumer takes the block
//   blk_first, blk_last             : block position within its message
//   msg_bits[63:0]                  : message length in bits, valid with blk_last
// Modports: master = byte producer / block consumer, slave = the padder.
interface sha256_padder_if;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [511:0] blk_data;
  logic         blk_valid;
  logic         blk_ready;
  logic         blk_first;
  logic         blk_last;
  logic [63:0]  msg_bits;

  modport master (
    output in_data, in_valid, in_last, blk_ready,
    input  in_ready, blk_data, blk_valid, blk_first, blk_last, msg_bits
  );

  modport slave (
    input  in_data, in_valid, in_last, blk_ready,
    output in_ready, blk_data, blk_valid, blk_first, blk_last, msg_bits
  );
endinterface

// File: rtl/sha256_padder.sv
// rtl/sha256_padder.sv - SHA-256 message padder: byte stream in, padded 512-bit blocks out
//
// Ports:
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : sha256_padder_if.slave (byte stream in, block handshake out)
// Parameters:
//   LEN_W   : width of the bit-length counter (<= 64), zero-extended into the length field
module sha256_padder #(
  parameter int LEN_W = 64
) (
  input  logic           clock,
  input  logic           reset_n,
  sha256_padder_if.slave bus
);

  typedef enum logic [1:0] {FILL, HOLD, PAD2, HOLD2} state_t;
  // Kind of second block owed after the current one.
  typedef enum logic [1:0] {PAD_NONE, PAD_LEN, PAD_FULL} pad_t;

  state_t             state_q, state_d;
  pad_t               pad2_q, pad2_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               arm_q, arm_d;
  logic [511:0]       data_q, data_d;
  logic               first_q, first_d;
  logic               last_q, last_d;
  logic [63:0]        msgb_q, msgb_d;

  logic [6:0]         n;         // bytes in the block including the current one
  logic [LEN_W-1:0]   len_inc;   // bit length including the current byte
  logic [63:0]        len_inc64;
  logic [63:0]        len_q64;
  logic [511:0]       fill_blk;  // block image if the current byte is accepted

  assign n         = {1'b0, cnt_q} + 7'd1;
  assign len_inc   = len_q + LEN_W'(8);
  assign len_inc64 = 64'(len_inc);
  assign len_q64   = 64'(len_q);

  assign bus.in_ready  = (state_q == FILL);
  assign bus.blk_valid = (state_q == HOLD) || (state_q == HOLD2);
  assign bus.blk_data  = data_q;
  assign bus.blk_first = first_q;
  assign bus.blk_last  = last_q;
  assign bus.msg_bits  = msgb_q;

  // Bytes past the write position are rewritten every cycle, so stale bytes
  // from the previous block never survive into a padded block.
  always_comb begin
    fill_blk = data_q;
    for (int i = 0; i < 64; i++) begin
      if (7'(i) == {1'b0, cnt_q}) begin
        fill_blk[511-8*i -: 8] = bus.in_data;
      end else if (7'(i) > {1'b0, cnt_q}) begin
        fill_blk[511-8*i -: 8] = (bus.in_last && (7'(i) == n)) ? 8'h80 : 8'h00;
      end
    end
    if (bus.in_last && (n <= 7'd55)) begin
      fill_blk[63:0] = len_inc64;
    end
  end

  always_comb begin
    state_d = state_q;
    pad2_d  = pad2_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    arm_d   = arm_q;
    data_d  = data_q;
    first_d = first_q;
    last_d  = last_q;
    msgb_d  = msgb_q;

    case (state_q)
      FILL: begin
        if (bus.in_valid) begin
          cnt_d  = cnt_q + 6'd1;
          len_d  = len_inc;
          data_d = fill_blk;
          if (bus.in_last || (n == 7'd64)) begin
            state_d = HOLD;
            first_d = arm_q;
            arm_d   = 1'b0;
            last_d  = 1'b0;
            pad2_d  = PAD_NONE;
            if (bus.in_last) begin
              if (n <= 7'd55) begin
                last_d = 1'b1;
                msgb_d = len_inc64;
              end else if (n == 7'd64) begin
                pad2_d = PAD_FULL;
              end else begin
                pad2_d = PAD_LEN;
              end
            end
          end
        end
      end

      HOLD: begin
        if (bus.blk_ready) begin
          cnt_d = 6'd0;
          if (pad2_q != PAD_NONE) begin
            // Second block is loaded on this handshake edge: no valid bubble.
            data_d  = (pad2_q == PAD_FULL) ? {8'h80, 440'd0, len_q64}
                                           : {448'd0, len_q64};
            first_d = 1'b0;
            last_d  = 1'b1;
            msgb_d  = len_q64;
            pad2_d  = PAD_NONE;
            state_d = HOLD2;
          end else if (last_q) begin
            len_d   = '0;
            arm_d   = 1'b1;
            state_d = FILL;
          end else begin
            state_d = FILL;
          end
        end
      end

      HOLD2: begin
        if (bus.blk_ready) begin
          cnt_d   = 6'd0;
          len_d   = '0;
          arm_d   = 1'b1;
          state_d = FILL;
        end
      end

      // Never entered; the second block goes straight to HOLD2.
      PAD2: state_d = HOLD2;

      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FILL;
      pad2_q  <= PAD_NONE;
      cnt_q   <= 6'd0;
      len_q   <= '0;
      arm_q   <= 1'b1;
      data_q  <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      msgb_q  <= 64'd0;
    end else begin
      state_q <= state_d;
      pad2_q  <= pad2_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      arm_q   <= arm_d;
      data_q  <= data_d;
      first_q <= first_d;
      last_q  <= last_d;
      msgb_q  <= msgb_d;
    end
  end

endmodule

// File: tb/tb_sha256_padder.sv
// tb/tb_sha256_padder.sv - self-checking bench for sha256_padder
module tb_sha256_padder;

  typedef logic [7:0]   u8_t;
  typedef u8_t          bq_t [$];
  typedef logic [511:0] blk_q_t [$];

  logic clock;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  sha256_padder_if bus ();

  sha256_padder #(.LEN_W(64)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [639:0] pk();
    return 640'({bus.blk_valid, bus.blk_first, bus.blk_last, bus.msg_bits, bus.blk_data});
  endfunction

  function automatic bq_t str2q(input string s);
    bq_t q;
    q = {};
    for (int i = 0; i < s.len(); i++) q.push_back(u8_t'(s[i]));
    return q;
  endfunction

  function automatic bq_t fillq(input int cnt, input u8_t v);
    bq_t q;
    q = {};
    for (int i = 0; i < cnt; i++) q.push_back(v);
    return q;
  endfunction

  function automatic bq_t rand_msg(input int cnt);
    bq_t q;
    q = {};
    for (int i = 0; i < cnt; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  // Textbook padding: append 0x80, zeros to 56 mod 64, then 64-bit length; cut into blocks.
  task automatic build_blocks(input bq_t msg, output blk_q_t blks);
    bq_t          p;
    logic [63:0]  bits;
    logic [511:0] b;
    p = msg;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    bits = 64'(msg.size()) * 64'd8;
    for (int k = 7; k >= 0; k--) p.push_back(bits[8*k +: 8]);
    blks = {};
    for (int j = 0; j < p.size() / 64; j++) begin
      b = '0;
      for (int m = 0; m < 64; m++) b = {b[503:0], p[64*j+m]};
      blks.push_back(b);
    end
  endtask

  task automatic run_msg(input bq_t msg, input int vpct, input int rpct);
    blk_q_t       eb;
    int           idx, seen, cyc, nb;
    logic         hold, exp_v;
    logic [639:0] held;
    logic [63:0]  bits;
    build_blocks(msg, eb);
    nb   = eb.size();
    bits = 64'(msg.size()) * 64'd8;
    idx  = 0;
    seen = 0;
    cyc  = 0;
    hold = 1'b0;
    exp_v = 1'b0;
    held = '0;
    while (seen < nb && cyc < 4000) begin
      @(negedge clock);
      cyc++;
      if (exp_v) chk("no_bubble", 640'(bus.blk_valid), 640'(1'b1));
      exp_v = 1'b0;
      if (hold) chk("hold_stable", pk(), held);
      bus.blk_ready = (int'($urandom_range(99)) < rpct);
      if (idx < msg.size() && int'($urandom_range(99)) < vpct) begin
        bus.in_valid = 1'b1;
        bus.in_data  = msg[idx];
        bus.in_last  = (idx == msg.size() - 1);
      end else begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        bus.in_last  = 1'b0;
      end
      if (bus.in_valid && bus.in_ready) idx++;
      hold = 1'b0;
      if (bus.blk_valid) begin
        if (bus.blk_ready) begin
          chk("blk_data", 640'(bus.blk_data), 640'(eb[seen]));
          chk("blk_first", 640'(bus.blk_first), 640'(seen == 0));
          chk("blk_last", 640'(bus.blk_last), 640'(seen == nb - 1));
          if (seen == nb - 1) chk("msg_bits", 640'(bus.msg_bits), 640'(bits));
          if (seen == nb - 2 && idx == msg.size()) exp_v = 1'b1;
          seen++;
        end else begin
          hold = 1'b1;
          held = pk();
        end
      end
    end
    if (seen < nb) chk("block_timeout", 640'(seen), 640'(nb));
    @(negedge clock);
    bus.in_valid  = 1'b0;
    bus.blk_ready = 1'b0;
    chk("in_ready_after_last", 640'(bus.in_ready), 640'(1'b1));
    chk("valid_after_last", 640'(bus.blk_valid), 640'(1'b0));
  endtask

  initial begin
    bq_t    m;
    blk_q_t eb;
    reset_n       = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.blk_ready = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset_outputs", pk(), 640'd0);
    chk("reset_in_ready", 640'(bus.in_ready), 640'(1'b1));
    reset_n = 1'b1;

    run_msg(str2q("hello world"), 100, 100);
    run_msg(fillq(55, 8'h61), 100, 100);
    run_msg(fillq(56, 8'h61), 100, 100);
    run_msg(fillq(64, 8'h61), 100, 100);
    run_msg(fillq(56, 8'h61), 100, 40);
    run_msg(fillq(64, 8'h61), 70, 40);

    // Backpressure: block held for 10 cycles while a junk byte is offered.
    m = str2q("abc");
    build_blocks(m, eb);
    bus.blk_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      bus.in_valid = 1'b1;
      bus.in_data  = m[i];
      bus.in_last  = (i == 2);
    end
    @(negedge clock);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hff;
    bus.in_last  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      chk("bp_hold", pk(), 640'({1'b1, 1'b1, 1'b1, 64'd24, eb[0]}));
      chk("bp_in_ready", 640'(bus.in_ready), 640'(1'b0));
      @(negedge clock);
    end
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.blk_ready = 1'b1;
    @(posedge clock);
    #1;
    chk("bp_release_valid", 640'(bus.blk_valid), 640'(1'b0));
    chk("bp_release_ready", 640'(bus.in_ready), 640'(1'b1));
    @(negedge clock);
    bus.blk_ready = 1'b0;

    // Reset in the middle of a message.
    m = rand_msg(30);
    bus.blk_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      bus.in_valid = 1'b1;
      bus.in_data  = m[i];
      bus.in_last  = 1'b0;
    end
    @(negedge clock);
    bus.in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("midreset_outputs", pk(), 640'd0);
    chk("midreset_in_ready", 640'(bus.in_ready), 640'(1'b1));
    @(negedge clock);
    reset_n = 1'b1;
    run_msg(str2q("abc"), 100, 100);

    // Boundary lengths and random messages with random flow control.
    run_msg(rand_msg(1), 100, 100);
    run_msg(rand_msg(63), 80, 60);
    run_msg(rand_msg(119), 80, 60);
    run_msg(rand_msg(120), 80, 60);
    run_msg(rand_msg(128), 90, 50);
    for (int t = 0; t < 14; t++) begin
      run_msg(rand_msg(int'($urandom_range(200, 1))),
              int'($urandom_range(100, 40)), int'($urandom_range(100, 30)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
